// File: rtl/spi_byte_master.sv
// SPI mode-0 byte engine: drives SCK (idle low), shifts tx_data out MSB-first on MOSI
// and captures MISO on each SCK rising edge. Chip select is handled by the controller above.
module spi_byte_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [1:0]        dbg_state
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Handshake: start is accepted only in IDLE; tx_data is captured on that edge.
    // done pulses for one cycle as busy drops; rx_data is held until the next done.
    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOW;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    busy_d     = 1'b1;
                    bit_d      = '0;
                    div_d      = '0;
                end
            end
            LOW: begin
                if (div_q == DIV_LAST) begin
                    // MISO is sampled on the same clk edge that raises SCK.
                    state_d    = HIGH;
                    sck_d      = 1'b1;
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
                    div_d      = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HIGH: begin
                if (div_q == DIV_LAST) begin
                    sck_d = 1'b0;
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d   = IDLE;
                        mosi_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_shift_q;
                    end else begin
                        // MOSI only moves on the SCK falling edge.
                        state_d    = LOW;
                        bit_d      = bit_q + 1'b1;
                        tx_shift_d = tx_shift_q << 1;
                        mosi_d     = tx_shift_d[DATA_W-1];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: four instances (CLK_DIV 2, 1, 3, 255) sharing clk/rst_n,
// each with MISO selectable between MOSI loopback and a bench-driven level.
module tb_spi_byte_master;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] tx_v [4];
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] rx_v [4];
  logic [3:0] sck_v;
  logic [3:0] mosi_v;
  logic [3:0] miso_v;
  logic [3:0] loop_v;
  logic [3:0] miso_drv;
  logic [1:0] dbg_v [4];

  int n_checks = 0;
  int n_errors = 0;

  assign miso_v = (loop_v & mosi_v) | (~loop_v & miso_drv);

  spi_byte_master #(.CLK_DIV(2), .DATA_W(8)) u_div2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .tx_data(tx_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .rx_data(rx_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]),
    .dbg_state(dbg_v[0]));
  spi_byte_master #(.CLK_DIV(1), .DATA_W(8)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .tx_data(tx_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .rx_data(rx_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]),
    .dbg_state(dbg_v[1]));
  spi_byte_master #(.CLK_DIV(3), .DATA_W(8)) u_div3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .tx_data(tx_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .rx_data(rx_v[2]), .sck(sck_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]),
    .dbg_state(dbg_v[2]));
  spi_byte_master #(.CLK_DIV(255), .DATA_W(8)) u_div255 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .tx_data(tx_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .rx_data(rx_v[3]), .sck(sck_v[3]), .mosi(mosi_v[3]), .miso(miso_v[3]),
    .dbg_state(dbg_v[3]));

  // Clock and reset drive
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on instance idx. mode 0: MISO looped to MOSI; mode 1: MISO held at pat[0];
  // mode 2: MISO presents pat MSB-first, one bit per SCK period. poke>0 pulses start with
  // 0xFF that many cycles after accept, while the instance is busy.
  task automatic xfer(input int idx, input int div, input logic [7:0] data, input int mode,
                      input logic [7:0] pat, input logic [7:0] exp_rx, input int poke);
    int n = 0;
    int rises = 0;
    int hi_run = 0;
    int lo_run = 1;
    int bad_hi = 0;
    int bad_lo = 0;
    int glitch = 0;
    int lat = 0;
    logic got_done = 1'b0;
    logic busy_at_done = 1'b1;
    logic sck_at_done = 1'b1;
    logic mosi_at_done = 1'b1;
    logic [7:0] rx_at_done = 8'h00;
    logic [7:0] mseq = 8'h00;
    logic prev_sck;
    logic prev_mosi;
    loop_v[idx]   = (mode == 0);
    miso_drv[idx] = (mode == 1) ? pat[0] : pat[7];
    tx_v[idx]     = data;
    start_v[idx]  = 1'b1;
    tick;
    start_v[idx]  = 1'b0;
    check($sformatf("accept_busy%0d", idx), busy_v[idx], 1);
    check($sformatf("accept_mosi%0d", idx), mosi_v[idx], data[7]);
    prev_sck  = sck_v[idx];
    prev_mosi = mosi_v[idx];
    while (!got_done && n < 20 * div + 20) begin
      tick;
      n++;
      if (poke > 0 && n == poke) begin
        tx_v[idx]    = 8'hFF;
        start_v[idx] = 1'b1;
      end else begin
        start_v[idx] = 1'b0;
      end
      if (done_v[idx]) begin
        got_done     = 1'b1;
        lat          = n;
        rx_at_done   = rx_v[idx];
        busy_at_done = busy_v[idx];
        sck_at_done  = sck_v[idx];
        mosi_at_done = mosi_v[idx];
      end
      if (sck_v[idx] && !prev_sck) begin
        if (lo_run != div) bad_lo++;
        hi_run = 1;
        mseq   = {mseq[6:0], mosi_v[idx]};
        rises++;
        if (mode == 2 && rises < 8) miso_drv[idx] = pat[7 - rises];
      end else if (!sck_v[idx] && prev_sck) begin
        if (hi_run != div) bad_hi++;
        lo_run = 1;
      end else if (sck_v[idx]) begin
        hi_run++;
      end else begin
        lo_run++;
      end
      if (mosi_v[idx] != prev_mosi && !(!sck_v[idx] && prev_sck)) glitch++;
      prev_sck  = sck_v[idx];
      prev_mosi = mosi_v[idx];
    end
    start_v[idx] = 1'b0;
    check($sformatf("done_seen%0d", idx), got_done, 1);
    check($sformatf("latency%0d", idx), lat, 16 * div);
    check($sformatf("rx_data%0d", idx), rx_at_done, exp_rx);
    check($sformatf("busy_at_done%0d", idx), busy_at_done, 0);
    check($sformatf("sck_at_done%0d", idx), sck_at_done, 0);
    check($sformatf("mosi_at_done%0d", idx), mosi_at_done, 0);
    check($sformatf("sck_pulses%0d", idx), rises, 8);
    check($sformatf("mosi_bits%0d", idx), mseq, data);
    check($sformatf("sck_high_len%0d", idx), bad_hi, 0);
    check($sformatf("sck_low_len%0d", idx), bad_lo, 0);
    check($sformatf("mosi_glitch%0d", idx), glitch, 0);
    tick;
    check($sformatf("done_one_cycle%0d", idx), done_v[idx], 0);
  endtask

  initial begin
    int n;
    int falls;
    int rises;
    int extra_done;
    int d1;
    int d2;
    int ndone;
    int gap;
    int pulses;
    logic gap_done;
    logic prev_sck;
    logic [7:0] rx1;
    logic [7:0] rx2;

    rst_n    = 1'b0;
    start_v  = '0;
    loop_v   = '0;
    miso_drv = '0;
    for (int i = 0; i < 4; i++) tx_v[i] = 8'h00;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_sck%0d", i), sck_v[i], 0);
      check($sformatf("rst_mosi%0d", i), mosi_v[i], 0);
      check($sformatf("rst_busy%0d", i), busy_v[i], 0);
      check($sformatf("rst_done%0d", i), done_v[i], 0);
      check($sformatf("rst_rx%0d", i), rx_v[i], 0);
      check($sformatf("rst_state%0d", i), dbg_v[i], 0);
    end
    rst_n = 1'b1;
    tick;

    // CLK_DIV=2 directed transfers
    xfer(0, 2, 8'hA5, 0, 8'h00, 8'hA5, 0);
    xfer(0, 2, 8'h00, 1, 8'hFF, 8'hFF, 0);
    xfer(0, 2, 8'h3C, 2, 8'hC9, 8'hC9, 10);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done_v[0]) extra_done++;
    end
    check("ignored_start_no_done", extra_done, 0);
    check("ignored_start_idle", busy_v[0], 0);

    // Reset in the middle of the fourth SCK pulse
    loop_v[0]  = 1'b1;
    tx_v[0]    = 8'hC3;
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    falls    = 0;
    rises    = 0;
    prev_sck = sck_v[0];
    n        = 0;
    while (rises < 4 && n < 200) begin
      tick;
      n++;
      if (!sck_v[0] && prev_sck) falls++;
      if (sck_v[0] && !prev_sck) rises++;
      prev_sck = sck_v[0];
    end
    check("mid_pulses_seen", falls, 3);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mid_rst_sck", sck_v[0], 0);
    check("mid_rst_mosi", mosi_v[0], 0);
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_done", done_v[0], 0);
    check("mid_rst_rx", rx_v[0], 0);
    extra_done = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (done_v[0] || sck_v[0]) extra_done++;
    end
    check("mid_rst_quiet", extra_done, 0);
    xfer(0, 2, 8'h5A, 0, 8'h00, 8'h5A, 0);

    // Back-to-back at CLK_DIV=1 with start held high
    loop_v[1]  = 1'b1;
    tx_v[1]    = 8'h81;
    start_v[1] = 1'b1;
    tick;
    check("b2b_accept1", busy_v[1], 1);
    tx_v[1]  = 8'h7E;
    n        = 0;
    ndone    = 0;
    d1       = 0;
    d2       = 0;
    gap      = 0;
    gap_done = 1'b0;
    pulses   = 0;
    rx1      = 8'h00;
    rx2      = 8'h00;
    prev_sck = sck_v[1];
    while (ndone < 2 && n < 100) begin
      tick;
      n++;
      if (ndone == 1 && !gap_done) begin
        if (sck_v[1]) gap_done = 1'b1;
        else gap++;
      end
      if (ndone == 1 && n == d1 + 1) begin
        start_v[1] = 1'b0;
        check("b2b_accept2", busy_v[1], 1);
      end
      if (done_v[1]) begin
        ndone++;
        if (ndone == 1) begin
          d1  = n;
          rx1 = rx_v[1];
          gap = 1;
        end else begin
          d2  = n;
          rx2 = rx_v[1];
        end
      end
      if (sck_v[1] && !prev_sck) pulses++;
      prev_sck = sck_v[1];
    end
    start_v[1] = 1'b0;
    check("b2b_dones", ndone, 2);
    check("b2b_first_latency", d1, 16);
    check("b2b_spacing", d2 - d1, 17);
    check("b2b_rx1", rx1, 8'h81);
    check("b2b_rx2", rx2, 8'h7E);
    check("b2b_pulses", pulses, 16);
    check("b2b_gap_low", gap, 2);
    tick;

    // CLK_DIV sweep
    xfer(1, 1, 8'h96, 0, 8'h00, 8'h96, 0);
    xfer(2, 3, 8'h4B, 0, 8'h00, 8'h4B, 0);
    xfer(3, 255, 8'hA5, 0, 8'h00, 8'hA5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
